// File: rtl/datamover_ctrl_if.sv
// rtl/datamover_ctrl_if.sv - handshake bundle between requester, datamover_ctrl and datamover
// Purpose: groups the command, completion and datamover control channels.
// Signals:
//   cmd_valid/cmd_ready/cmd_tag            job requests into the controller
//   done_valid/done_ready/done_tag/timeout completion records out of the controller
//   dm_rstn/dm_instr_val/dm_data_rdy       control and status of the attached datamover
// Modports: master = requester/datamover side, slave = datamover_ctrl.
interface datamover_ctrl_if #(
  parameter int TAGW = 8
);
  logic            cmd_valid;
  logic            cmd_ready;
  logic [TAGW-1:0] cmd_tag;
  logic            dm_rstn;
  logic            dm_instr_val;
  logic            dm_data_rdy;
  logic            done_valid;
  logic            done_ready;
  logic [TAGW-1:0] done_tag;
  logic            done_timeout;

  modport master (
    output cmd_valid, cmd_tag, dm_data_rdy, done_ready,
    input  cmd_ready, dm_rstn, dm_instr_val, done_valid, done_tag, done_timeout
  );

  modport slave (
    input  cmd_valid, cmd_tag, dm_data_rdy, done_ready,
    output cmd_ready, dm_rstn, dm_instr_val, done_valid, done_tag, done_timeout
  );
endinterface

// File: rtl/datamover_ctrl.sv
// rtl/datamover_ctrl.sv - queues tagged jobs and sequences them through one datamover
// Purpose: command FIFO feeding an IDLE/RST/START/RUN/DONE sequencer; each job resets
//   the datamover, strobes it once, waits for completion and posts a tagged record.
// Ports:
//   clk, rst        sole clock, synchronous active-high reset
//   bus (slave)     cmd_*, done_*, dm_* channels (see datamover_ctrl_if)
//   busy            engine not idle or FIFO non-empty
//   job_count       saturating count of completion handshakes
// Configuration: define DATAMOVER_CTRL_WATCHDOG_EN to bound RUN by TIMEOUT_CYCLES.
module datamover_ctrl #(
  parameter int TAGW           = 8,
  parameter int DEPTH          = 4,
  parameter int RST_CYCLES     = 2,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic              clk,
  input  logic              rst,
  datamover_ctrl_if.slave   bus,
  output logic              busy,
  output logic [15:0]       job_count
);
  localparam int AW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int RCW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam logic [AW:0]    FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [RCW-1:0] RST_LAST = RCW'(RST_CYCLES - 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_RST   = 3'd1;
  localparam logic [2:0] S_START = 3'd2;
  localparam logic [2:0] S_RUN   = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  logic [2:0]      state;
  logic [TAGW-1:0] mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [AW:0]     count;
  logic [RCW-1:0]  rst_cnt;
  logic [TAGW-1:0] tag_q;
  logic            full;
  logic            empty;
  logic            push;
  logic            pop;
  logic            done_hs;

`ifdef DATAMOVER_CTRL_WATCHDOG_EN
  localparam int WDW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [WDW-1:0] WD_LAST = WDW'(TIMEOUT_CYCLES - 1);
  logic [WDW-1:0] wd_cnt;
  logic           timeout_q;
  assign bus.done_timeout = !rst && timeout_q;
`else
  logic unused_timeout_cycles;
  assign unused_timeout_cycles = (TIMEOUT_CYCLES > 0);
  assign bus.done_timeout      = 1'b0;
`endif

  assign full  = (count == FULL_CNT);
  assign empty = (count == '0);

  // Outputs are gated by rst so they hold reset values for the whole reset window,
  // not just after the first edge. cmd_ready looks at the registered count only, so
  // a same-cycle pop never makes room for a push into a full FIFO.
  assign bus.cmd_ready    = !rst && !full;
  assign bus.dm_rstn      = !rst && (state != S_RST);
  assign bus.dm_instr_val = !rst && (state == S_START);
  assign bus.done_valid   = !rst && (state == S_DONE);
  assign bus.done_tag     = rst ? '0 : tag_q;
  assign busy             = !rst && ((state != S_IDLE) || !empty);

  assign push    = bus.cmd_valid && bus.cmd_ready;
  assign pop     = (state == S_IDLE) && !empty;
  assign done_hs = bus.done_valid && bus.done_ready;

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= bus.cmd_tag;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      rst_cnt   <= '0;
      tag_q     <= '0;
      job_count <= '0;
`ifdef DATAMOVER_CTRL_WATCHDOG_EN
      wd_cnt    <= '0;
      timeout_q <= 1'b0;
`endif
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      if (push && !pop) begin
        count <= count + (AW+1)'(1);
      end else if (pop && !push) begin
        count <= count - (AW+1)'(1);
      end

      if (done_hs && (job_count != 16'hFFFF)) begin
        job_count <= job_count + 16'd1;
      end

      case (state)
        S_IDLE: begin
          if (!empty) begin
            tag_q   <= mem[rd_ptr];
            rst_cnt <= '0;
            state   <= S_RST;
          end
        end
        S_RST: begin
          if (rst_cnt == RST_LAST) begin
            state <= S_START;
          end else begin
            rst_cnt <= rst_cnt + RCW'(1);
          end
        end
        S_START: begin
`ifdef DATAMOVER_CTRL_WATCHDOG_EN
          wd_cnt <= '0;
`endif
          state <= S_RUN;
        end
        S_RUN: begin
          // Completion outranks the watchdog when both land in the same cycle.
          if (bus.dm_data_rdy) begin
`ifdef DATAMOVER_CTRL_WATCHDOG_EN
            timeout_q <= 1'b0;
`endif
            state <= S_DONE;
          end
`ifdef DATAMOVER_CTRL_WATCHDOG_EN
          else if (wd_cnt == WD_LAST) begin
            timeout_q <= 1'b1;
            state     <= S_DONE;
          end else begin
            wd_cnt <= wd_cnt + WDW'(1);
          end
`endif
        end
        S_DONE: begin
          if (bus.done_ready) begin
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_datamover_ctrl.sv
// tb/tb_datamover_ctrl.sv - self-checking bench for datamover_ctrl
`timescale 1ns/1ps
module tb_datamover_ctrl;
  localparam int TAGW = 8;
  localparam int DEPTH = 4;
  localparam int RSTC = 2;
  localparam int TOUT = 16;
`ifdef DATAMOVER_CTRL_WATCHDOG_EN
  localparam bit WD = 1'b1;
`else
  localparam bit WD = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        busy;
  logic [15:0] job_count;
  int          checks = 0;
  int          errors = 0;

  datamover_ctrl_if #(.TAGW(TAGW)) bus();

  datamover_ctrl #(
    .TAGW(TAGW), .DEPTH(DEPTH), .RST_CYCLES(RSTC), .TIMEOUT_CYCLES(TOUT)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus), .busy(busy), .job_count(job_count)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL global_timeout: actual=running required=finished");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_reset_outputs(input string p);
    chk({p, "_cmd_ready"}, bus.cmd_ready, 1'b0);
    chk({p, "_dm_rstn"}, bus.dm_rstn, 1'b0);
    chk({p, "_instr_val"}, bus.dm_instr_val, 1'b0);
    chk({p, "_done_valid"}, bus.done_valid, 1'b0);
    chk({p, "_done_tag"}, bus.done_tag, 8'h00);
    chk({p, "_done_timeout"}, bus.done_timeout, 1'b0);
    chk({p, "_busy"}, busy, 1'b0);
    chk({p, "_job_count"}, job_count, 16'h0000);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.cmd_valid = 1'b0; bus.cmd_tag = 8'h00; bus.dm_data_rdy = 1'b0; bus.done_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk_reset_outputs("rst");
    rst = 1'b0;
    #1;
    chk("post_rst_cmd_ready", bus.cmd_ready, 1'b1);
    chk("post_rst_dm_rstn", bus.dm_rstn, 1'b1);
  endtask

  // Single-job walkthrough: one record per clock, inputs applied before the edge and
  // outputs compared after it.
  typedef struct {
    logic       cv;
    logic [7:0] tag;
    logic       dr;
    logic       drdy;
    logic       e_cr;
    logic       e_rstn;
    logic       e_iv;
    logic       e_dv;
    logic       e_to;
    logic       e_busy;
    logic [7:0] e_dtag;
    logic [15:0] e_jc;
  } vec_t;

  task automatic run_table();
    vec_t tbl[10];
    tbl[0] = '{1'b1, 8'h11, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 16'd0};
    tbl[1] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 16'd0};
    tbl[2] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 16'd0};
    tbl[3] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 8'h00, 16'd0};
    tbl[4] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 16'd0};
    tbl[5] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 16'd0};
    tbl[6] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 16'd0};
    tbl[7] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 8'h11, 16'd0};
    tbl[8] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 16'd1};
    tbl[9] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 16'd1};
    for (int i = 0; i < 10; i++) begin
      bus.cmd_valid = tbl[i].cv; bus.cmd_tag = tbl[i].tag;
      bus.dm_data_rdy = tbl[i].dr; bus.done_ready = tbl[i].drdy;
      @(negedge clk);
      chk($sformatf("vec%0d_cmd_ready", i), bus.cmd_ready, tbl[i].e_cr);
      chk($sformatf("vec%0d_dm_rstn", i), bus.dm_rstn, tbl[i].e_rstn);
      chk($sformatf("vec%0d_instr_val", i), bus.dm_instr_val, tbl[i].e_iv);
      chk($sformatf("vec%0d_done_valid", i), bus.done_valid, tbl[i].e_dv);
      chk($sformatf("vec%0d_busy", i), busy, tbl[i].e_busy);
      chk($sformatf("vec%0d_job_count", i), job_count, tbl[i].e_jc);
      if (tbl[i].e_dv) begin
        chk($sformatf("vec%0d_done_tag", i), bus.done_tag, tbl[i].e_dtag);
        chk($sformatf("vec%0d_done_timeout", i), bus.done_timeout, tbl[i].e_to);
      end
    end
    bus.cmd_valid = 1'b0; bus.dm_data_rdy = 1'b0; bus.done_ready = 1'b0;
  endtask

  // Five back-to-back tags against a stalled completion channel, then drain in order.
  task automatic seq_fill();
    int sent = 0;
    int got = 0;
    int w = 0;
    logic acc;
    bus.dm_data_rdy = 1'b1; bus.done_ready = 1'b0;
    for (int c = 0; c < 40 && sent < 5; c++) begin
      bus.cmd_valid = 1'b1; bus.cmd_tag = 8'(sent + 1);
      acc = bus.cmd_ready;
      @(negedge clk);
      if (acc) sent++;
    end
    chk("fill_sent", sent, 5);
    bus.cmd_valid = 1'b1; bus.cmd_tag = 8'h06;
    while (!bus.done_valid && w < 20) begin @(negedge clk); w++; end
    for (int s = 0; s < 10; s++) begin
      @(negedge clk);
      chk("stall_done_valid", bus.done_valid, 1'b1);
      chk("stall_done_tag", bus.done_tag, 8'h01);
      chk("stall_no_instr_val", bus.dm_instr_val, 1'b0);
      chk("stall_cmd_ready_full", bus.cmd_ready, 1'b0);
    end
    bus.cmd_valid = 1'b0;
    bus.done_ready = 1'b1;
    for (int c = 0; c < 200 && got < 5; c++) begin
      if (bus.done_valid) begin
        got++;
        chk("drain_order", bus.done_tag, 8'(got));
      end
      @(negedge clk);
    end
    chk("drain_count", got, 5);
    chk("drain_job_count", job_count, 16'd5);
    chk("drain_idle", busy, 1'b0);
    bus.done_ready = 1'b0; bus.dm_data_rdy = 1'b0;
  endtask

  task automatic run_job(input logic [7:0] t, input int rdy_at, input int max_k,
                         output logic done, output int run_len, output logic to);
    int w = 0;
    done = 1'b0; run_len = 0; to = 1'b0;
    bus.cmd_valid = 1'b1; bus.cmd_tag = t; bus.dm_data_rdy = 1'b0; bus.done_ready = 1'b0;
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    while (!bus.dm_instr_val && w < 20) begin @(negedge clk); w++; end
    chk($sformatf("job%0h_start", t), bus.dm_instr_val, 1'b1);
    @(negedge clk);
    for (int k = 1; k <= max_k; k++) begin
      bus.dm_data_rdy = (rdy_at != 0) && (k >= rdy_at);
      @(negedge clk);
      if (bus.done_valid) begin
        done = 1'b1; run_len = k; to = bus.done_timeout;
        break;
      end
    end
  endtask

  task automatic ack();
    bus.done_ready = 1'b1;
    @(negedge clk);
    bus.done_ready = 1'b0; bus.dm_data_rdy = 1'b0;
  endtask

  task automatic seq_watchdog();
    logic done;
    logic to;
    int len;
    run_job(8'hA1, 0, 40, done, len, to);
    chk("wd_expire_done", done, WD);
    if (done) begin
      chk("wd_expire_len", len, TOUT);
      chk("wd_expire_timeout", to, 1'b1);
    end else begin
      chk("norun_still_busy", busy, 1'b1);
      bus.dm_data_rdy = 1'b1;
      @(negedge clk);
      chk("late_rdy_done_valid", bus.done_valid, 1'b1);
      chk("late_rdy_timeout", bus.done_timeout, 1'b0);
    end
    ack();
    run_job(8'hA2, TOUT, 40, done, len, to);
    chk("tie_done", done, 1'b1);
    chk("tie_len", len, TOUT);
    chk("tie_timeout", to, 1'b0);
    chk("tie_tag", bus.done_tag, 8'hA2);
    ack();
    run_job(8'hA3, 20, 40, done, len, to);
    chk("late_done", done, 1'b1);
    chk("late_len", len, WD ? TOUT : 20);
    chk("late_timeout", to, WD);
    ack();
  endtask

  task automatic seq_reset_mid();
    int w = 0;
    logic saw_dv = 1'b0;
    logic saw_iv = 1'b0;
    bus.dm_data_rdy = 1'b0; bus.done_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bus.cmd_valid = 1'b1; bus.cmd_tag = 8'(8'hC0 + i);
      @(negedge clk);
    end
    bus.cmd_valid = 1'b0;
    while (!bus.dm_instr_val && w < 20) begin @(negedge clk); w++; end
    chk("rmid_started", bus.dm_instr_val, 1'b1);
    @(negedge clk);
    chk("rmid_busy_before", busy, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    chk_reset_outputs("rmid");
    rst = 1'b0; bus.done_ready = 1'b1; bus.dm_data_rdy = 1'b1;
    repeat (20) begin
      @(negedge clk);
      saw_dv = saw_dv | bus.done_valid;
      saw_iv = saw_iv | bus.dm_instr_val;
    end
    chk("rmid_no_done", saw_dv, 1'b0);
    chk("rmid_no_start", saw_iv, 1'b0);
    chk("rmid_idle", busy, 1'b0);
    chk("rmid_job_count", job_count, 16'd0);
    bus.done_ready = 1'b0; bus.dm_data_rdy = 1'b0;
  endtask

  // Transaction-level reference: a tag queue, one in-flight job aged in clocks since
  // it left the queue, and a pending completion record.
  task automatic seq_random(input int ncyc);
    logic [7:0] mq[$];
    logic       active = 1'b0;
    logic       done_pend = 1'b0;
    int         age = 0;
    int         lat = 0;
    int         k;
    logic [7:0] jtag = 8'h00;
    logic       jto = 1'b0;
    logic [15:0] jc = 16'd0;
    logic       cv, dr, drdy, will_push;
    logic [7:0] tag;
    for (int cyc = 0; cyc < ncyc; cyc++) begin
      cv = 1'($urandom_range(0, 1));
      tag = 8'($urandom);
      drdy = ($urandom_range(0, 3) != 0);
      k = age - RSTC - 1;
      if (active && age >= RSTC + 2) dr = (k >= lat);
      else if (active) dr = 1'b0;
      else dr = 1'($urandom_range(0, 1));
      bus.cmd_valid = cv; bus.cmd_tag = tag; bus.dm_data_rdy = dr; bus.done_ready = drdy;

      will_push = cv && (mq.size() < DEPTH);
      if (!active && !done_pend) begin
        if (mq.size() > 0) begin
          jtag = mq.pop_front(); active = 1'b1; age = 1;
          lat = WD ? $urandom_range(1, 24) : $urandom_range(1, 6);
        end
      end else if (active) begin
        if (age >= RSTC + 2 && dr) begin
          active = 1'b0; done_pend = 1'b1; jto = 1'b0;
        end else if (age >= RSTC + 2 && WD && k == TOUT) begin
          active = 1'b0; done_pend = 1'b1; jto = 1'b1;
        end else begin
          age++;
        end
      end else if (drdy) begin
        done_pend = 1'b0;
        if (jc != 16'hFFFF) jc++;
      end
      if (will_push) mq.push_back(tag);

      @(negedge clk);
      chk("rnd_cmd_ready", bus.cmd_ready, mq.size() < DEPTH);
      chk("rnd_dm_rstn", bus.dm_rstn, !(active && age <= RSTC));
      chk("rnd_instr_val", bus.dm_instr_val, active && (age == RSTC + 1));
      chk("rnd_done_valid", bus.done_valid, done_pend);
      chk("rnd_busy", busy, active || done_pend || (mq.size() > 0));
      chk("rnd_job_count", job_count, jc);
      if (done_pend) begin
        chk("rnd_done_tag", bus.done_tag, jtag);
        chk("rnd_done_timeout", bus.done_timeout, jto);
      end
    end
    bus.cmd_valid = 1'b0; bus.done_ready = 1'b0; bus.dm_data_rdy = 1'b0;
  endtask

  initial begin
    do_reset();
    run_table();
    do_reset();
    seq_fill();
    do_reset();
    seq_watchdog();
    do_reset();
    seq_reset_mid();
    do_reset();
    seq_random(1500);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/datamover_ctrl.md
DATAMOVER_CTRL -- requirements
Module: datamover_ctrl

Interface
REQ-001 Parameter TAGW, default 8: width of job tag.
REQ-002 Parameter DEPTH, default 4: command FIFO entries; power of two, >=2.
REQ-003 Parameter RST_CYCLES, default 2: cycles dm_rstn is held low before each job; >=1.
REQ-004 Parameter TIMEOUT_CYCLES, default 1024: watchdog limit in RUN; >=1.
REQ-005 clk  in  1  sole clock; all logic on rising edge.
REQ-006 rst  in  1  synchronous, active-high reset.
REQ-007 cmd_valid  in  1  job request valid.
REQ-008 cmd_ready  out  1  FIFO can accept; equals !full.
REQ-009 cmd_tag  in  TAGW  job identifier.
REQ-010 dm_rstn  out  1  active-low synchronous reset to datamover.
REQ-011 dm_instr_val  out  1  start strobe to datamover.
REQ-012 dm_data_rdy  in  1  datamover completion flag (sticky until datamover reset).
REQ-013 done_valid  out  1  completion record valid.
REQ-014 done_ready  in  1  completion record accepted.
REQ-015 done_tag  out  TAGW  tag of completed job.
REQ-016 done_timeout  out  1  job ended by watchdog, not dm_data_rdy.
REQ-017 busy  out  1  high in any state other than IDLE, or when FIFO non-empty.
REQ-018 job_count  out  16  completed-job count (handshakes on done channel).

Function
REQ-019 Command accepted when cmd_valid && cmd_ready at a clock edge; cmd_tag written to FIFO tail.
REQ-020 cmd_ready derives from registered FIFO count only; a pop in the same cycle as a full FIFO does not admit a push.
REQ-021 FIFO pointers wrap modulo DEPTH; order strictly FIFO; no entry lost or duplicated.
REQ-022 States: IDLE, RST, START, RUN, DONE.
REQ-023 IDLE: FIFO non-empty -> pop head into tag register, next state RST; otherwise stay.
REQ-024 RST: dm_rstn=0 for exactly RST_CYCLES cycles, then START.
REQ-025 START: dm_instr_val=1 for exactly one cycle, then RUN; dm_instr_val=0 in all other states.
REQ-026 RUN: dm_data_rdy=1 -> DONE, done_timeout=0; watchdog count reaching TIMEOUT_CYCLES -> DONE, done_timeout=1; dm_data_rdy wins if both in same cycle.
REQ-027 Watchdog counter cleared on entry to RUN, increments each RUN cycle.
REQ-028 DONE: done_valid=1, done_tag/done_timeout stable until done_ready; on handshake -> IDLE, job_count+1 saturating at 16'hFFFF.
REQ-029 dm_rstn=1 in IDLE, START, RUN, DONE.
REQ-030 dm_data_rdy ignored outside RUN.
REQ-031 Pushes accepted in every state, including during DONE stall.

Reset
REQ-032 While rst=1: state IDLE, FIFO empty, cmd_ready=0, dm_rstn=0, dm_instr_val=0, done_valid=0, done_tag=0, done_timeout=0, busy=0, job_count=0.
REQ-033 First cycle after rst deasserts: cmd_ready=1, dm_rstn=1.
REQ-034 rst mid-job discards FIFO contents and in-flight job; no done record produced.

Configuration
REQ-035 Macro DATAMOVER_CTRL_WATCHDOG_EN: defined -> watchdog per REQ-026/027; undefined -> no counter, RUN exits only on dm_data_rdy, done_timeout tied 0, TIMEOUT_CYCLES unused.

Verification
REQ-036 rst 1 then 0; push tag 8'h11; dm_data_rdy=1 at 3rd RUN cycle -> dm_rstn low 2 cycles, one dm_instr_val pulse, done_tag=8'h11, done_timeout=0, job_count=1.
REQ-037 Push 5 tags 1..5 back-to-back, DEPTH=4, engine stalled in DONE -> cmd_ready low after 4 queued, completions in order 1..5.
REQ-038 Watchdog on, TIMEOUT_CYCLES=16, dm_data_rdy held 0 -> DONE after 16 RUN cycles, done_timeout=1; undefined macro -> stays in RUN.
REQ-039 dm_data_rdy=1 on the cycle watchdog reaches limit -> done_timeout=0.
REQ-040 done_ready held 0 for 10 cycles -> done_valid/done_tag stable, no new dm_instr_val.
REQ-041 rst asserted during RUN with 2 queued -> all outputs at reset values next cycle, no done_valid afterwards.
